mem_bus_master: RTL and testbench

- Bus-2 initiator: the cache-side end of the line-transfer protocol that the memory model answers.
- Accepts one cache-line request (read or write) from the cache controller and issues READ_LINE / WRITE_LINE on C2/A2/D2.
- Transfers the line in 16-bit beats, collects the RESPONSE, and returns the read line or a write acknowledgement upstream.
- Owns bus-2 turnaround and the response timeout.

---
 rtl/bus2_pkg.sv | 41 ++++
 rtl/bus2_tristate.sv | 31 +++
 rtl/mem_bus_master.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus2_pkg.sv
// ============================================================================
// Module   : bus2_pkg
// Brief    : Shared bus-2 definitions: C2 command codes, default bus widths,
//            master FSM state codes and the beat-count helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus2_pkg;

  // Default bus geometry
  localparam int ADDR2_W      = 14;
  localparam int DATA2_W      = 16;
  localparam int CTR2_W       = 2;
  localparam int LINE_BYTES_D = 16;
  localparam int TIMEOUT_D    = 255;

  // C2 command / response encoding
  typedef enum logic [1:0] {
    C2_NOP        = 2'b00,
    C2_RESPONSE   = 2'b01,
    C2_READ_LINE  = 2'b10,
    C2_WRITE_LINE = 2'b11
  } c2_cmd_e;

  // Master FSM state codes
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CMD      = 3'd1;
  localparam logic [2:0] ST_HANDOVER = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_RECV     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  // Number of D2 beats needed to move one cache line
  function automatic int calc_beats(input int line_bytes, input int data_w);
    return (line_bytes * 8) / data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus2_tristate.sv
// ============================================================================
// Module   : bus2_tristate
// Brief    : Output-enable drivers for the shared C2/D2 bus-2 lines. The
//            master only drives when its enable is high; otherwise the lines
//            are left to the responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus2_tristate #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 2
) (
  input  logic              c2_oe,
  input  logic [CTRL_W-1:0] c2_out,
  output logic [CTRL_W-1:0] c2_in,
  input  logic              d2_oe,
  input  logic [DATA_W-1:0] d2_out,
  output logic [DATA_W-1:0] d2_in,
  inout  wire  [CTRL_W-1:0] C2,
  inout  wire  [DATA_W-1:0] D2
);

  assign C2    = c2_oe ? c2_out : {CTRL_W{1'bz}};
  assign D2    = d2_oe ? d2_out : {DATA_W{1'bz}};
  assign c2_in = C2;
  assign d2_in = D2;

endmodule

`default_nettype wire

// File: rtl/mem_bus_master.sv
// ============================================================================
// Module   : mem_bus_master
// Brief    : Bus-2 initiator. Takes one cache-line read/write request,
//            issues READ_LINE/WRITE_LINE on C2/A2/D2, moves the line in
//            D2-wide beats, waits for RESPONSE with a timeout and returns
//            the read line or a write acknowledgement upstream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_master
  import bus2_pkg::*;
#(
  parameter int ADDR2_BUS_SIZE = ADDR2_W,
  parameter int DATA2_BUS_SIZE = DATA2_W,
  parameter int CTR2_BUS_SIZE  = CTR2_W,
  parameter int LINE_BYTES     = LINE_BYTES_D,
  parameter int TIMEOUT        = TIMEOUT_D
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR2_BUS_SIZE-1:0] req_addr,
  input  logic [LINE_BYTES*8-1:0]   req_wdata,
  output logic                      rsp_valid,
  output logic                      rsp_error,
  output logic [LINE_BYTES*8-1:0]   rsp_rdata,
  output logic [ADDR2_BUS_SIZE-1:0] A2,
  inout  wire  [DATA2_BUS_SIZE-1:0] D2,
  inout  wire  [CTR2_BUS_SIZE-1:0]  C2
);

  localparam int BEATS  = calc_beats(LINE_BYTES, DATA2_BUS_SIZE);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [BCNT_W-1:0]        LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [TCNT_W-1:0]        TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0]        TCNT_MAX  = TCNT_W'(TIMEOUT);
  localparam logic [CTR2_BUS_SIZE-1:0] CMD_NOP   = CTR2_BUS_SIZE'(C2_NOP);
  localparam logic [CTR2_BUS_SIZE-1:0] CMD_RSP   = CTR2_BUS_SIZE'(C2_RESPONSE);
  localparam logic [CTR2_BUS_SIZE-1:0] CMD_RD    = CTR2_BUS_SIZE'(C2_READ_LINE);
  localparam logic [CTR2_BUS_SIZE-1:0] CMD_WR    = CTR2_BUS_SIZE'(C2_WRITE_LINE);

  logic [2:0]                  r_state;
  logic                        r_write;
  logic                        r_err;
  logic [ADDR2_BUS_SIZE-1:0]   r_addr;
  logic [LINE_W-1:0]           r_wdata;
  // Holds beats 0..BEATS-2; the last beat goes straight into rsp_rdata
  logic [LINE_W-DATA2_BUS_SIZE-1:0] r_rbuf;
  logic [LINE_W-1:0]           r_rdata;
  logic [BCNT_W-1:0]           r_beat;
  logic [TCNT_W-1:0]           r_tcnt;

  logic                        w_c2_oe;
  logic                        w_d2_oe;
  logic [CTR2_BUS_SIZE-1:0]    w_c2_out;
  logic [CTR2_BUS_SIZE-1:0]    w_c2_in;
  logic [DATA2_BUS_SIZE-1:0]   w_d2_out;
  logic [DATA2_BUS_SIZE-1:0]   w_d2_in;
  logic                        w_rsp_seen;

  // X/Z/NOP on C2 never compare equal to RESPONSE, so they read as "no response"
  assign w_rsp_seen = (w_c2_in == CMD_RSP);

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_error = (r_state == ST_DONE) && r_err;
  assign rsp_rdata = r_rdata;
  assign A2        = r_addr;

  // Bus drive: C2 only in CMD/HANDOVER, D2 only during write CMD beats
  always_comb begin
    w_c2_oe  = 1'b0;
    w_c2_out = CMD_NOP;
    w_d2_oe  = 1'b0;
    w_d2_out = r_wdata[r_beat*DATA2_BUS_SIZE +: DATA2_BUS_SIZE];
    if (r_state == ST_CMD) begin
      w_c2_oe  = 1'b1;
      w_c2_out = r_write ? CMD_WR : CMD_RD;
      w_d2_oe  = r_write;
    end else if (r_state == ST_HANDOVER) begin
      w_c2_oe  = 1'b1;
    end
  end

  // Transaction FSM with beat and response-timeout counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_rdata <= '0;
      r_beat  <= '0;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_err   <= 1'b0;
            r_beat  <= '0;
            r_tcnt  <= '0;
            r_state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (!r_write || (r_beat == LAST_BEAT)) begin
            r_beat  <= '0;
            r_state <= ST_HANDOVER;
          end else begin
            r_beat  <= r_beat + 1'b1;
          end
        end
        ST_HANDOVER: begin
          r_tcnt  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_rsp_seen) begin
            if (r_write) begin
              r_state <= ST_DONE;
            end else begin
              r_rbuf[DATA2_BUS_SIZE-1:0] <= w_d2_in;
              r_beat  <= BCNT_W'(1);
              r_state <= ST_RECV;
            end
          end else if (r_tcnt >= TCNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_tcnt != TCNT_MAX) begin
            r_tcnt  <= r_tcnt + 1'b1;
          end
        end
        ST_RECV: begin
          if (!w_rsp_seen) begin
            // Broken burst: partial line is dropped, rsp_rdata untouched
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_beat == LAST_BEAT) begin
            r_rdata <= {w_d2_in, r_rbuf};
            r_state <= ST_DONE;
          end else begin
            r_rbuf[r_beat*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] <= w_d2_in;
            r_beat  <= r_beat + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  bus2_tristate #(
    .DATA_W (DATA2_BUS_SIZE),
    .CTRL_W (CTR2_BUS_SIZE)
  ) u_tristate (
    .c2_oe  (w_c2_oe),
    .c2_out (w_c2_out),
    .c2_in  (w_c2_in),
    .d2_oe  (w_d2_oe),
    .d2_out (w_d2_out),
    .d2_in  (w_d2_in),
    .C2     (C2),
    .D2     (D2)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_master.sv
// ============================================================================
// Module   : tb_mem_bus_master
// Brief    : Self-checking bench for mem_bus_master with a bus-2 responder
//            and a line-level reference model of the returned read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_master;
  import bus2_pkg::*;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int CW = 2;
  localparam int LB = 16;
  localparam int TO = 255;
  localparam int NB = LB * 8 / DW;
  localparam int LW = LB * 8;

  // Released lines float to all-ones through the pull-ups
  localparam logic [CW-1:0] C2_REL = 2'b11;
  localparam logic [DW-1:0] D2_REL = 16'hFFFF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_error;
  logic [LW-1:0] rsp_rdata;
  logic [AW-1:0] A2;
  tri1  [DW-1:0] D2;
  tri1  [CW-1:0] C2;

  logic          rc2_oe = 1'b0;
  logic [CW-1:0] rc2 = '0;
  logic          rd2_oe = 1'b0;
  logic [DW-1:0] rd2 = '0;
  assign C2 = rc2_oe ? rc2 : {CW{1'bz}};
  assign D2 = rd2_oe ? rd2 : {DW{1'bz}};

  int            checks = 0;
  int            errors = 0;
  logic [LW-1:0] model_rdata = '0;

  always #5 clk = ~clk;

  mem_bus_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_error (rsp_error),
    .rsp_rdata (rsp_rdata),
    .A2        (A2),
    .D2        (D2),
    .C2        (C2)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_drive(input logic [CW-1:0] c, input logic [DW-1:0] d);
    rc2_oe = 1'b1; rc2 = c; rd2_oe = 1'b1; rd2 = d;
  endtask

  task automatic bus_release();
    rc2_oe = 1'b0; rd2_oe = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Read: responder sends nbeats beats of line; nbeats < NB breaks the burst
  task automatic read_txn(input logic [AW-1:0] addr, input int delay, input int nbeats,
                          input logic [LW-1:0] line, input bit keep, input logic [AW-1:0] next_addr);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    chk("rd_ready_idle", req_ready, 1'b1);
    tick();
    chk("rd_cmd_c2", C2, C2_READ_LINE);
    chk("rd_cmd_a2", A2, addr);
    chk("rd_cmd_ready", req_ready, 1'b0);
    if (keep) req_addr = next_addr; else req_valid = 1'b0;
    tick();
    chk("rd_ho_c2", C2, C2_NOP);
    chk("rd_ho_d2", D2, D2_REL);
    tick();
    chk("rd_wait_c2", C2, C2_REL);
    chk("rd_wait_d2", D2, D2_REL);
    repeat (delay) tick();
    chk("rd_wait_valid", rsp_valid, 1'b0);
    for (int k = 0; k < nbeats; k++) begin
      bus_drive(C2_RESPONSE, line[k*DW +: DW]);
      tick();
    end
    if (nbeats < NB) begin
      bus_drive(C2_NOP, 16'h0000);
      tick();
    end
    bus_release();
    if (nbeats == NB) model_rdata = line;
    chk("rd_done_valid", rsp_valid, 1'b1);
    chk("rd_done_error", rsp_error, (nbeats < NB) ? 1'b1 : 1'b0);
    chk("rd_done_rdata", rsp_rdata, model_rdata);
    chk("rd_done_a2", A2, addr);
    tick();
    chk("rd_end_valid", rsp_valid, 1'b0);
    chk("rd_end_ready", req_ready, 1'b1);
    chk("rd_end_a2", A2, addr);
  endtask

  task automatic write_txn(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int delay);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = line;
    chk("wr_ready_idle", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      chk("wr_cmd_c2", C2, C2_WRITE_LINE);
      chk("wr_cmd_d2", D2, line[k*DW +: DW]);
      chk("wr_cmd_a2", A2, addr);
      tick();
    end
    chk("wr_ho_c2", C2, C2_NOP);
    chk("wr_ho_d2", D2, D2_REL);
    tick();
    chk("wr_wait_d2", D2, D2_REL);
    repeat (delay) tick();
    chk("wr_wait_valid", rsp_valid, 1'b0);
    bus_drive(C2_RESPONSE, 16'h0000);
    tick();
    bus_release();
    chk("wr_done_valid", rsp_valid, 1'b1);
    chk("wr_done_error", rsp_error, 1'b0);
    chk("wr_done_rdata", rsp_rdata, model_rdata);
    tick();
    chk("wr_end_valid", rsp_valid, 1'b0);
    chk("wr_end_ready", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            cyc;
    bit            bus_ok;
    bit            saw_valid;
    logic [LW-1:0] line;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    int            op;

    // Reset state, while reset is held
    #12;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_error", rsp_error, 1'b0);
    chk("rst_rdata", rsp_rdata, '0);
    chk("rst_a2", A2, '0);
    chk("rst_c2", C2, C2_REL);
    chk("rst_d2", D2, D2_REL);
    tick();
    reset_n = 1'b1;
    tick();

    // Directed read of address 5 with ascending byte pattern
    line = 128'h0F0E0D0C0B0A09080706050403020100;
    read_txn(14'h0005, 2, NB, line, 1'b0, '0);
    chk("dir_rd_line", rsp_rdata, 128'h0F0E0D0C0B0A09080706050403020100);

    // Directed write to top address
    write_txn(14'h3FFF, 128'h00112233445566778899AABBCCDDEEFF, 1);

    // Read with no responder: timeout
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0123;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    cyc = 0;
    bus_ok = 1'b1;
    while (!rsp_valid && cyc < TO + 50) begin
      if (C2 !== C2_REL || D2 !== D2_REL) bus_ok = 1'b0;
      tick();
      cyc++;
    end
    chk("to_cycles", cyc, TO);
    chk("to_bus_released", bus_ok, 1'b1);
    chk("to_error", rsp_error, 1'b1);
    chk("to_rdata", rsp_rdata, model_rdata);
    tick();
    chk("to_end_ready", req_ready, 1'b1);

    // Burst broken after beat 3
    read_txn(14'h0ABC, 0, 4, rand_line(), 1'b0, '0);
    chk("drop_rdata_kept", rsp_rdata, 128'h0F0E0D0C0B0A09080706050403020100);

    // Reset during write beat 4
    line = rand_line();
    line[4*DW +: DW] = 16'h5A5A;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h1555; req_wdata = line;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    chk("mid_pre_d2", D2, 16'h5A5A);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_d2", D2, D2_REL);
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_a2", A2, '0);
    model_rdata = '0;
    tick();
    reset_n = 1'b1;
    saw_valid = 1'b0;
    repeat (20) begin
      tick();
      if (rsp_valid) saw_valid = 1'b1;
    end
    chk("mid_no_valid", saw_valid, 1'b0);
    chk("mid_ready", req_ready, 1'b1);
    chk("mid_rdata", rsp_rdata, '0);

    // Back-to-back reads with req_valid held high
    a1 = 14'h0042;
    a2 = 14'h2A17;
    read_txn(a1, 1, NB, rand_line(), 1'b1, a2);
    read_txn(a2, 0, NB, rand_line(), 1'b0, '0);

    // Randomized mix of transactions
    for (int i = 0; i < 10; i++) begin
      op = $urandom_range(0, 2);
      a1 = AW'($urandom);
      if (op == 0)
        read_txn(a1, $urandom_range(0, 6), NB, rand_line(), 1'b0, '0);
      else if (op == 1)
        read_txn(a1, $urandom_range(0, 6), $urandom_range(1, NB - 1), rand_line(), 1'b0, '0);
      else
        write_txn(a1, rand_line(), $urandom_range(0, 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
